// File: rtl/fifo_cdc_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: syncs the Gray write pointer, issues
// RAM reads, absorbs the 1-cycle RAM latency and returns the Gray read pointer.
module fifo_cdc_rd_ctrl #(
  parameter  int width_p = 8,
  parameter  int depth_p = 16,
  localparam int AW      = $clog2(depth_p)
) (
  input  logic               pclk_i,
  input  logic               reset_i,
  input  logic [AW:0]        wr_ptr_gray_i,
  output logic [AW:0]        rd_ptr_gray_o,
  output logic               ram_rd_valid_o,
  output logic [AW-1:0]      ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  logic [AW:0] wr_gray_s1, wr_gray_s2;
  logic [AW:0] wr_ptr_bin_sync;
  logic [AW:0] rd_ptr_bin, next_bin;
  logic        empty, issue;

  // Plain two-flop synchroniser; nothing may sit between the stages.
  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_gray_s1 <= '0;
      wr_gray_s2 <= '0;
    end else begin
      wr_gray_s1 <= wr_ptr_gray_i;
      wr_gray_s2 <= wr_gray_s1;
    end
  end

  always_comb begin
    wr_ptr_bin_sync[AW] = wr_gray_s2[AW];
    for (int i = AW-1; i >= 0; i--)
      wr_ptr_bin_sync[i] = wr_ptr_bin_sync[i+1] ^ wr_gray_s2[i];
  end

  assign empty          = (rd_ptr_bin == wr_ptr_bin_sync);
  assign issue          = !empty && (!valid_o || ready_i);
  assign next_bin       = rd_ptr_bin + {{AW{1'b0}}, 1'b1};
  assign ram_rd_valid_o = issue;
  assign ram_rd_addr_o  = rd_ptr_bin[AW-1:0];
  // RAM holds its output while no new read is issued, so this stays stable under stall.
  assign data_o         = ram_rd_data_i;

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_bin    <= '0;
      rd_ptr_gray_o <= '0;
      valid_o       <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr_bin    <= next_bin;
        rd_ptr_gray_o <= next_bin ^ (next_bin >> 1);
      end
      if (issue)        valid_o <= 1'b1;
      else if (ready_i) valid_o <= 1'b0;
    end
  end

endmodule
